// File: rtl/mips_trace_buffer_pkg.sv
// Shared types for the MIPS post-commit trace buffer:
// state encoding and the 96-bit {pc, instr, alu} record layout.
package mips_trace_pkg;

  localparam int REC_W     = 96;
  localparam int PC_LSB    = 64;
  localparam int INSTR_LSB = 32;
  localparam int ALU_LSB   = 0;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_POST  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    ARMED = ST_ARMED,
    POST  = ST_POST,
    DONE  = ST_DONE
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] alu;
  } rec_t;

endpackage

// File: rtl/mips_trace_buffer_if.sv
// Capture bus from the retiring stage and valid/ready drain port.
// master drives captures and consumes records; slave is the buffer.
interface mips_trace_buffer_if;
  logic        cap_valid;
  logic [31:0] cap_pc;
  logic [31:0] cap_instr;
  logic [31:0] cap_alu;
  logic        rd_valid;
  logic        rd_ready;
  logic [31:0] rd_pc;
  logic [31:0] rd_instr;
  logic [31:0] rd_alu;

  modport master (
    output cap_valid, cap_pc, cap_instr, cap_alu, rd_ready,
    input  rd_valid, rd_pc, rd_instr, rd_alu
  );

  modport slave (
    input  cap_valid, cap_pc, cap_instr, cap_alu, rd_ready,
    output rd_valid, rd_pc, rd_instr, rd_alu
  );
endinterface

// File: rtl/mips_trace_buffer_ram.sv
// Record storage: one synchronous write port, one async read port.
// No reset; contents are don't-care until written.
module trace_ram
  import mips_trace_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [REC_W-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [REC_W-1:0] rdata
);

  logic [REC_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mips_trace_buffer.sv
// Circular post-commit trace capture with PC trigger, post-trigger
// window and oldest-first valid/ready drain.
module mips_trace_buffer
  import mips_trace_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  mips_trace_buffer_if.slave bus,
  input  logic          arm,
  input  logic [31:0]   trig_pc,
  output logic          armed,
  output logic          triggered,
  output logic          done,
  output logic [CW-1:0] count
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  state_t        state;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] post_cnt;

  logic          we;
  logic          hit;
  logic          rd_fire;
  logic [AW-1:0] wr_nx;
  logic [CW-1:0] cnt_nx;
  logic [AW-1:0] oldest;
  rec_t          wrec;
  rec_t          rrec;

  assign we      = bus.cap_valid &&
                   (state == ARMED || state == POST);
  assign hit     = bus.cap_pc == trig_pc;
  assign wr_nx   = wr_ptr + AW'(1);
  assign cnt_nx  = (count == FULL) ? count : count + CW'(1);
  // Oldest record once the current write lands; a full buffer wraps to wr_nx.
  assign oldest  = wr_nx - cnt_nx[AW-1:0];
  assign rd_fire = bus.rd_valid && bus.rd_ready;

  assign wrec = '{pc: bus.cap_pc,
                  instr: bus.cap_instr,
                  alu: bus.cap_alu};

  trace_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (wr_ptr),
    .wdata (wrec),
    .raddr (rd_ptr),
    .rdata (rrec)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      post_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (arm) begin
            state  <= ARMED;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
          end
        end
        ARMED: begin
          if (bus.cap_valid) begin
            wr_ptr <= wr_nx;
            count  <= cnt_nx;
            if (hit) begin
              if (POST_TRIG == 0) begin
                state  <= DONE;
                rd_ptr <= oldest;
              end else begin
                state    <= POST;
                post_cnt <= AW'(POST_TRIG);
              end
            end
          end
        end
        POST: begin
          if (bus.cap_valid) begin
            wr_ptr   <= wr_nx;
            count    <= cnt_nx;
            post_cnt <= post_cnt - AW'(1);
            if (post_cnt == AW'(1)) begin
              state  <= DONE;
              rd_ptr <= oldest;
            end
          end
        end
        DONE: begin
          if (count == '0) begin
            state <= IDLE;
          end else if (rd_fire) begin
            rd_ptr <= rd_ptr + AW'(1);
            count  <= count - CW'(1);
            if (count == CW'(1)) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign armed     = (state == ARMED) || (state == POST);
  assign triggered = (state == POST) || (state == DONE);
  assign done      = (state == DONE);

  assign bus.rd_valid = done && (count != '0);
  assign bus.rd_pc    = done ? rrec.pc    : '0;
  assign bus.rd_instr = done ? rrec.instr : '0;
  assign bus.rd_alu   = done ? rrec.alu   : '0;

endmodule

// File: tb/tb_mips_trace_buffer.sv
// Directed bench for mips_trace_buffer (DEPTH=16, POST_TRIG=4).
// Inputs change on negedge; outputs are checked on negedge.
module tb_mips_trace_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        arm = 1'b0;
  logic [31:0] trig_pc = '0;
  logic        armed;
  logic        triggered;
  logic        done;
  logic [4:0]  count;

  int tests = 0;
  int fails = 0;

  mips_trace_buffer_if bus();

  mips_trace_buffer #(.DEPTH(16), .POST_TRIG(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .arm       (arm),
    .trig_pc   (trig_pc),
    .armed     (armed),
    .triggered (triggered),
    .done      (done),
    .count     (count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ins_of(input logic [31:0] pc);
    return 32'h0800_0000 ^ pc;
  endfunction

  function automatic logic [31:0] alu_of(input logic [31:0] pc);
    return pc + 32'h100;
  endfunction

  task automatic feed(input logic [31:0] pc, input logic v);
    bus.cap_valid = v;
    bus.cap_pc    = pc;
    bus.cap_instr = ins_of(pc);
    bus.cap_alu   = alu_of(pc);
    @(negedge clk);
    bus.cap_valid = 1'b0;
  endtask

  task automatic do_arm(input logic [31:0] pc);
    trig_pc = pc;
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    tests++;
    if (armed !== 1'b1 || count !== 5'd0) begin
      fails++;
      $display("FAIL arm: armed=%b count=%0d want 1/0", armed, count);
    end
  endtask

  task automatic drain(input logic [31:0] first, input int n);
    logic [31:0] e;
    bus.rd_ready = 1'b1;
    for (int k = 0; k < n; k++) begin
      e = first + 32'(k * 4);
      tests++;
      if (bus.rd_valid !== 1'b1 || bus.rd_pc !== e ||
          bus.rd_instr !== ins_of(e) || bus.rd_alu !== alu_of(e)) begin
        fails++;
        $display("FAIL drain[%0d]: v=%b pc=%h ins=%h alu=%h want pc=%h",
                 k, bus.rd_valid, bus.rd_pc, bus.rd_instr, bus.rd_alu, e);
      end
      @(negedge clk);
    end
    bus.rd_ready = 1'b0;
    tests++;
    if (bus.rd_valid !== 1'b0 || done !== 1'b0 || armed !== 1'b0 ||
        count !== 5'd0 || bus.rd_pc !== 32'd0) begin
      fails++;
      $display("FAIL drain_end: v=%b done=%b armed=%b count=%0d pc=%h want idle",
               bus.rd_valid, done, armed, count, bus.rd_pc);
    end
  endtask

  task automatic test_reset;
    tests++;
    if (armed !== 1'b0 || triggered !== 1'b0 || done !== 1'b0 ||
        count !== 5'd0 || bus.rd_valid !== 1'b0 || bus.rd_pc !== 32'd0 ||
        bus.rd_instr !== 32'd0 || bus.rd_alu !== 32'd0) begin
      fails++;
      $display("FAIL reset: a=%b t=%b d=%b cnt=%0d v=%b want all 0",
               armed, triggered, done, count, bus.rd_valid);
    end
  endtask

  task automatic test_no_wrap;
    do_arm(32'h20);
    for (int i = 0; i <= 12; i++) begin
      feed(32'(i * 4), 1'b1);
      if (i == 7) begin
        tests++;
        if (triggered !== 1'b0) begin
          fails++;
          $display("FAIL pre_trig: triggered=%b want 0", triggered);
        end
      end
      if (i == 8) begin
        tests++;
        if (triggered !== 1'b1 || done !== 1'b0 || armed !== 1'b1) begin
          fails++;
          $display("FAIL trig: t=%b d=%b a=%b want 1/0/1",
                   triggered, done, armed);
        end
      end
      if (i == 11) begin
        tests++;
        if (done !== 1'b0) begin
          fails++;
          $display("FAIL early_done: done=%b want 0", done);
        end
      end
    end
    tests++;
    if (done !== 1'b1 || count !== 5'd13 || armed !== 1'b0) begin
      fails++;
      $display("FAIL nowrap_done: done=%b count=%0d armed=%b want 1/13/0",
               done, count, armed);
    end
    drain(32'h00, 13);
  endtask

  task automatic test_wrap;
    do_arm(32'h60);
    for (int i = 0; i <= 28; i++) feed(32'(i * 4), 1'b1);
    tests++;
    if (done !== 1'b1 || count !== 5'd16) begin
      fails++;
      $display("FAIL wrap_done: done=%b count=%0d want 1/16", done, count);
    end
    drain(32'h34, 16);
  endtask

  task automatic test_gaps;
    do_arm(32'h08);
    feed(32'h00, 1'b1);
    feed(32'h04, 1'b1);
    feed(32'h08, 1'b1);
    feed(32'h0C, 1'b1);
    feed(32'hDEAD_0000, 1'b0);
    feed(32'h10, 1'b1);
    feed(32'hDEAD_0004, 1'b0);
    feed(32'h14, 1'b1);
    feed(32'hDEAD_0008, 1'b0);
    tests++;
    if (done !== 1'b0 || triggered !== 1'b1 || count !== 5'd6) begin
      fails++;
      $display("FAIL gaps_mid: done=%b trig=%b count=%0d want 0/1/6",
               done, triggered, count);
    end
    feed(32'h18, 1'b1);
    tests++;
    if (done !== 1'b1 || count !== 5'd7) begin
      fails++;
      $display("FAIL gaps_done: done=%b count=%0d want 1/7", done, count);
    end
    drain(32'h00, 7);
  endtask

  task automatic test_back_to_back;
    int exp_i;
    int cyc;
    logic rdy;
    do_arm(32'h20);
    for (int i = 0; i <= 12; i++) feed(32'(i * 4), 1'b1);
    bus.rd_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (bus.rd_valid !== 1'b1 || bus.rd_pc !== 32'h00) begin
        fails++;
        $display("FAIL hold[%0d]: v=%b pc=%h want 1/00",
                 k, bus.rd_valid, bus.rd_pc);
      end
      @(negedge clk);
    end
    exp_i = 0;
    cyc = 0;
    rdy = 1'b1;
    while (exp_i < 13 && cyc < 60) begin
      tests++;
      if (bus.rd_valid !== 1'b1 || bus.rd_pc !== 32'(exp_i * 4)) begin
        fails++;
        $display("FAIL bp[%0d]: v=%b pc=%h want pc=%h",
                 cyc, bus.rd_valid, bus.rd_pc, 32'(exp_i * 4));
      end
      bus.rd_ready = rdy;
      @(negedge clk);
      if (rdy) exp_i++;
      rdy = ~rdy;
      cyc++;
    end
    bus.rd_ready = 1'b0;
    tests++;
    if (exp_i != 13 || bus.rd_valid !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL bp_end: got=%0d v=%b done=%b want 13/0/0",
               exp_i, bus.rd_valid, done);
    end
  endtask

  task automatic test_edge;
    trig_pc = 32'h20;
    arm = 1'b1;
    feed(32'h20, 1'b1);
    arm = 1'b0;
    tests++;
    if (count !== 5'd0 || armed !== 1'b1 || triggered !== 1'b0) begin
      fails++;
      $display("FAIL arm_cap: count=%0d armed=%b trig=%b want 0/1/0",
               count, armed, triggered);
    end
    for (int i = 0; i <= 12; i++) feed(32'(i * 4), 1'b1);
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    tests++;
    if (done !== 1'b1 || armed !== 1'b0 || count !== 5'd13 ||
        bus.rd_pc !== 32'h00) begin
      fails++;
      $display("FAIL arm_done: done=%b armed=%b count=%0d pc=%h want 1/0/13/00",
               done, armed, count, bus.rd_pc);
    end
    drain(32'h00, 13);
  endtask

  task automatic test_reset_post;
    do_arm(32'h20);
    for (int i = 0; i <= 10; i++) feed(32'(i * 4), 1'b1);
    tests++;
    if (triggered !== 1'b1 || done !== 1'b0 || count !== 5'd11) begin
      fails++;
      $display("FAIL pre_rst: trig=%b done=%b count=%0d want 1/0/11",
               triggered, done, count);
    end
    #2 reset = 1'b1;
    #1;
    tests++;
    if (armed !== 1'b0 || triggered !== 1'b0 || done !== 1'b0 ||
        count !== 5'd0 || bus.rd_valid !== 1'b0) begin
      fails++;
      $display("FAIL async_rst: a=%b t=%b d=%b cnt=%0d v=%b want all 0",
               armed, triggered, done, count, bus.rd_valid);
    end
    @(negedge clk);
    reset = 1'b0;
    test_no_wrap();
  endtask

  initial begin
    bus.cap_valid = 1'b0;
    bus.cap_pc    = '0;
    bus.cap_instr = '0;
    bus.cap_alu   = '0;
    bus.rd_ready  = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    reset = 1'b0;
    @(negedge clk);
    test_no_wrap();
    test_wrap();
    test_gaps();
    test_back_to_back();
    test_edge();
    test_reset_post();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
